// File: rtl/policy_server_mc.sv
// Multi-channel policy lookup server: shared valid-tagged policy table behind a
// round-robin arbiter and a two-stage lookup pipeline with a saturating miss counter.
module policy_server_mc #(
  parameter int                NUM_CH         = 2,
  parameter int                DATA_W         = 32,
  parameter int                ADDR_W         = 4,
  parameter logic [DATA_W-1:0] DEFAULT_POLICY = '0,
  parameter int                CNT_W          = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_wr_en,
  input  logic [ADDR_W-1:0]        cfg_wr_addr,
  input  logic [DATA_W-1:0]        cfg_wr_data,
  input  logic                     cfg_clr,
  input  logic [NUM_CH-1:0]        req_valid,
  input  logic [NUM_CH*ADDR_W-1:0] req_addr,
  output logic [NUM_CH-1:0]        req_ready,
  output logic [NUM_CH-1:0]        rsp_valid,
  output logic [NUM_CH*DATA_W-1:0] rsp_data,
  output logic [NUM_CH-1:0]        rsp_hit,
  output logic [CNT_W-1:0]         miss_cnt,
  output logic                     busy
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [DATA_W-1:0]        r_table [DEPTH];
  logic [DEPTH-1:0]         r_valid;
  logic [CH_W-1:0]          r_rr;
  logic                     r_s1_vld;
  logic [CH_W-1:0]          r_s1_ch;
  logic [ADDR_W-1:0]        r_s1_addr;
  logic [NUM_CH-1:0]        r_rsp_valid;
  logic [NUM_CH-1:0]        r_rsp_hit;
  logic [NUM_CH*DATA_W-1:0] r_rsp_data;
  logic [CNT_W-1:0]         r_miss_cnt;
  logic                     r_busy;

  logic                     w_cfg_act;
  logic [NUM_CH-1:0]        w_grant;
  logic                     w_found;
  logic [CH_W-1:0]          w_win_ch;
  logic [ADDR_W-1:0]        w_win_addr;
  logic                     w_xfer;
  logic                     w_rd_hit;
  logic [DATA_W-1:0]        w_rd_word;
  logic [NUM_CH-1:0]        w_rsp_valid_nx;
  logic [NUM_CH-1:0]        w_rsp_hit_nx;
  logic [NUM_CH*DATA_W-1:0] w_rsp_data_nx;

  function automatic logic [CH_W-1:0] rr_idx(input logic [CH_W-1:0] base, input int k);
    rr_idx = CH_W'((int'(base) + 1 + k) % NUM_CH);
  endfunction

  assign w_cfg_act = cfg_wr_en | cfg_clr;

  // Round-robin search starting after the last winner; config traffic blocks all grants.
  always_comb begin
    w_grant = '0;
    w_found = 1'b0;
    w_win_ch = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (rst && !w_cfg_act && !w_found && req_valid[rr_idx(r_rr, k)]) begin
        w_found = 1'b1;
        w_win_ch = rr_idx(r_rr, k);
        w_grant[rr_idx(r_rr, k)] = 1'b1;
      end else begin
        w_found = w_found;
      end
    end
    w_win_addr = req_addr[int'(w_win_ch)*ADDR_W +: ADDR_W];
  end

  assign w_xfer    = w_found;
  assign req_ready = w_grant;

  // S2 read: table contents as they stand before any write on this edge.
  always_comb begin
    w_rd_hit = r_valid[r_s1_addr];
    w_rd_word = w_rd_hit ? r_table[r_s1_addr] : DEFAULT_POLICY;
    w_rsp_valid_nx = '0;
    w_rsp_hit_nx = '0;
    w_rsp_data_nx = '0;
    if (r_s1_vld) begin
      w_rsp_valid_nx[r_s1_ch] = 1'b1;
      w_rsp_hit_nx[r_s1_ch] = w_rd_hit;
      w_rsp_data_nx[int'(r_s1_ch)*DATA_W +: DATA_W] = w_rd_word;
    end else begin
      w_rsp_valid_nx = '0;
    end
  end

  // Policy word storage; a write colliding with a clear is discarded.
  always_ff @(posedge clk) begin
    if (rst && cfg_wr_en && !cfg_clr) begin
      r_table[cfg_wr_addr] <= cfg_wr_data;
    end
  end

  // Valid bits: clear has priority over write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid <= '0;
    end else if (cfg_clr) begin
      r_valid <= '0;
    end else if (cfg_wr_en) begin
      r_valid[cfg_wr_addr] <= 1'b1;
    end
  end

  // Arbiter pointer, pipeline stages, responses and miss counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rr        <= CH_W'(NUM_CH - 1);
      r_s1_vld    <= 1'b0;
      r_s1_ch     <= '0;
      r_s1_addr   <= '0;
      r_rsp_valid <= '0;
      r_rsp_hit   <= '0;
      r_rsp_data  <= '0;
      r_miss_cnt  <= '0;
      r_busy      <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_rr <= w_win_ch;
      end
      r_s1_vld    <= w_xfer;
      r_s1_ch     <= w_win_ch;
      r_s1_addr   <= w_win_addr;
      r_rsp_valid <= w_rsp_valid_nx;
      r_rsp_hit   <= w_rsp_hit_nx;
      r_rsp_data  <= w_rsp_data_nx;
      if (r_s1_vld && !w_rd_hit && (r_miss_cnt != '1)) begin
        r_miss_cnt <= r_miss_cnt + CNT_W'(1);
      end
      r_busy <= w_xfer | r_s1_vld;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_hit   = r_rsp_hit;
  assign rsp_data  = r_rsp_data;
  assign miss_cnt  = r_miss_cnt;
  assign busy      = r_busy;

endmodule
